// File: rtl/divisor_nb.sv
// Button-driven WIDTH-bit divider: operands are edited with up/down/ok presses and
// a restoring divider yields one quotient bit per cycle, shown on the LED bank.
module divisor_nb #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_n,
    input  logic             down_n,
    input  logic             ok_n,
    output logic [WIDTH-1:0] leds,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             div_zero
);

    typedef enum logic [2:0] {
        ENTER_NUM,
        ENTER_DEN,
        DIVIDE,
        SHOW_Q,
        SHOW_R
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

    state_t           state, state_nx;
    logic             up_prev, down_prev, ok_prev;
    logic             up_press, down_press, ok_press;
    logic             edit_inc, edit_dec;
    logic [WIDTH-1:0] num, den;
    logic [WIDTH-1:0] quotient, remainder;
    logic [WIDTH-1:0] dvd_sh, dvs, part_rem;
    logic [WIDTH:0]   shifted, trial;
    logic             fits, last_iter;
    logic [4:0]       iter;
    logic             zero_flag;

    always_comb begin
        up_press   = up_prev & ~up_n;
        down_press = down_prev & ~down_n;
        ok_press   = ok_prev & ~ok_n;
        edit_inc   = up_press & ~down_press & ~ok_press;
        edit_dec   = down_press & ~up_press & ~ok_press;
    end

    // The restored remainder always fits in WIDTH bits; only the shifted trial value
    // needs the extra bit, whose borrow out of the subtraction doubles as the compare.
    always_comb begin
        shifted   = {part_rem, dvd_sh[WIDTH-1]};
        trial     = shifted - {1'b0, dvs};
        fits      = ~trial[WIDTH];
        last_iter = (iter == LAST_ITER);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ENTER_NUM;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ENTER_NUM: if (ok_press) state_nx = ENTER_DEN;
            ENTER_DEN: if (ok_press) state_nx = DIVIDE;
            DIVIDE:    if (dvs == '0 || last_iter) state_nx = SHOW_Q;
            SHOW_Q:    if (ok_press) state_nx = SHOW_R;
            SHOW_R:    if (ok_press) state_nx = ENTER_NUM;
            default:   state_nx = ENTER_NUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_prev   <= 1'b1;
            down_prev <= 1'b1;
            ok_prev   <= 1'b1;
            num       <= '0;
            den       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dvd_sh    <= '0;
            dvs       <= '0;
            part_rem  <= '0;
            iter      <= '0;
            zero_flag <= 1'b0;
        end else begin
            up_prev   <= up_n;
            down_prev <= down_n;
            ok_prev   <= ok_n;
            case (state)
                ENTER_NUM: begin
                    if (edit_inc)      num <= num + 1'b1;
                    else if (edit_dec) num <= num - 1'b1;
                end
                ENTER_DEN: begin
                    if (ok_press) begin
                        dvd_sh   <= num;
                        dvs      <= den;
                        part_rem <= '0;
                        iter     <= '0;
                    end else if (edit_inc) begin
                        den <= den + 1'b1;
                    end else if (edit_dec) begin
                        den <= den - 1'b1;
                    end
                end
                DIVIDE: begin
                    if (dvs == '0) begin
                        quotient  <= '1;
                        remainder <= dvd_sh;
                        zero_flag <= 1'b1;
                    end else begin
                        // Dividend register shifts out MSB first and collects quotient bits.
                        part_rem <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                        dvd_sh   <= {dvd_sh[WIDTH-2:0], fits};
                        iter     <= iter + 5'd1;
                        if (last_iter) begin
                            quotient  <= {dvd_sh[WIDTH-2:0], fits};
                            remainder <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                            zero_flag <= 1'b0;
                        end
                    end
                end
                SHOW_R: if (ok_press) zero_flag <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        leds     = '0;
        sel      = 2'b00;
        busy     = 1'b0;
        div_zero = 1'b0;
        case (state)
            ENTER_NUM: leds = num;
            ENTER_DEN: begin
                leds = den;
                sel  = 2'b01;
            end
            DIVIDE: begin
                sel  = 2'b10;
                busy = 1'b1;
            end
            SHOW_Q: begin
                leds     = quotient;
                sel      = 2'b10;
                div_zero = zero_flag;
            end
            SHOW_R: begin
                leds     = remainder;
                sel      = 2'b11;
                div_zero = zero_flag;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_divisor_nb.sv
// Self-checking bench for divisor_nb: a 4-bit and an 8-bit instance driven through
// button presses and compared against plain arithmetic on the entered operands.
module tb_divisor_nb;

    logic       clk = 1'b0;
    logic       rst;
    logic       up4_n, down4_n, ok4_n, up8_n, down8_n, ok8_n;
    logic [3:0] leds4;
    logic [7:0] leds8;
    logic [1:0] sel4, sel8;
    logic       busy4, busy8, dz4, dz8;

    int checks = 0;
    int errors = 0;
    int m_num[2];
    int m_den[2];

    always #5 clk = ~clk;

    divisor_nb #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .up_n(up4_n), .down_n(down4_n), .ok_n(ok4_n),
        .leds(leds4), .sel(sel4), .busy(busy4), .div_zero(dz4)
    );

    divisor_nb #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .up_n(up8_n), .down_n(down8_n), .ok_n(ok8_n),
        .leds(leds8), .sel(sel8), .busy(busy8), .div_zero(dz8)
    );

    function automatic int o_leds(input bit w8);
        return w8 ? int'(leds8) : int'(leds4);
    endfunction

    function automatic int o_sel(input bit w8);
        return w8 ? int'(sel8) : int'(sel4);
    endfunction

    function automatic bit o_busy(input bit w8);
        return w8 ? busy8 : busy4;
    endfunction

    function automatic bit o_dz(input bit w8);
        return w8 ? dz8 : dz4;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input bit w8, input bit u, input bit d, input bit o);
        if (w8) begin
            up8_n = ~u; down8_n = ~d; ok8_n = ~o;
        end else begin
            up4_n = ~u; down4_n = ~d; ok4_n = ~o;
        end
    endtask

    task automatic press(input bit w8, input bit u, input bit d, input bit o);
        drive(w8, u, d, o);
        tick();
        drive(w8, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        m_num = '{0, 0};
        m_den = '{0, 0};
    endtask

    // Shortest up/down path from the current operand value to target, modulo 2^W.
    task automatic set_val(input bit w8, input bit is_den, input int target);
        int m, cur, diff;
        m    = w8 ? 256 : 16;
        cur  = is_den ? m_den[w8] : m_num[w8];
        diff = (target - cur + m) % m;
        if (diff <= m / 2) repeat (diff) press(w8, 1'b1, 1'b0, 1'b0);
        else               repeat (m - diff) press(w8, 1'b0, 1'b1, 1'b0);
        if (is_den) m_den[w8] = target;
        else        m_num[w8] = target;
    endtask

    // From ENTER_DEN: press ok, count busy cycles (bounded), optionally jabbing buttons.
    task automatic run_divide(input bit w8, input bit noise, output int cycles);
        drive(w8, 1'b0, 1'b0, 1'b1);
        tick();
        drive(w8, 1'b0, 1'b0, 1'b0);
        cycles = 0;
        while (o_busy(w8) && cycles < 200) begin
            cycles++;
            if (noise)
                drive(w8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            tick();
        end
        drive(w8, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({sel4, busy4, dz4, leds4} !== 8'h00) begin
            errors++; $display("FAIL reset4 sel/busy/dz/leds=%b want 00000000", {sel4, busy4, dz4, leds4});
        end
        checks++; if ({sel8, busy8, dz8, leds8} !== 12'h000) begin
            errors++; $display("FAIL reset8 sel/busy/dz/leds=%b want 0", {sel8, busy8, dz8, leds8});
        end
    endtask

    task automatic test_basic();
        int cyc;
        set_val(1'b0, 1'b0, 13);
        checks++; if (sel4 !== 2'b00 || leds4 !== 4'd13) begin
            errors++; $display("FAIL basic_num sel=%b leds=%0d want 00/13", sel4, leds4);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        set_val(1'b0, 1'b1, 3);
        checks++; if (sel4 !== 2'b01 || leds4 !== 4'd3) begin
            errors++; $display("FAIL basic_den sel=%b leds=%0d want 01/3", sel4, leds4);
        end
        run_divide(1'b0, 1'b0, cyc);
        checks++; if (cyc !== 4) begin
            errors++; $display("FAIL basic_busy cycles=%0d want 4", cyc);
        end
        checks++; if (sel4 !== 2'b10 || leds4 !== 4'd4 || dz4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++; $display("FAIL basic_quot sel=%b leds=%0d dz=%b busy=%b want 10/4/0/0", sel4, leds4, dz4, busy4);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (sel4 !== 2'b11 || leds4 !== 4'd1) begin
            errors++; $display("FAIL basic_rem sel=%b leds=%0d want 11/1", sel4, leds4);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (sel4 !== 2'b00 || leds4 !== 4'd13) begin
            errors++; $display("FAIL basic_back sel=%b leds=%0d want 00/13", sel4, leds4);
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        set_val(1'b0, 1'b0, 9);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        set_val(1'b0, 1'b1, 0);
        run_divide(1'b0, 1'b0, cyc);
        checks++; if (cyc !== 1) begin
            errors++; $display("FAIL dz_busy cycles=%0d want 1", cyc);
        end
        checks++; if (sel4 !== 2'b10 || leds4 !== 4'd15 || dz4 !== 1'b1) begin
            errors++; $display("FAIL dz_quot sel=%b leds=%0d dz=%b want 10/15/1", sel4, leds4, dz4);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (sel4 !== 2'b11 || leds4 !== 4'd9 || dz4 !== 1'b1) begin
            errors++; $display("FAIL dz_rem sel=%b leds=%0d dz=%b want 11/9/1", sel4, leds4, dz4);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (sel4 !== 2'b00 || leds4 !== 4'd9 || dz4 !== 1'b0) begin
            errors++; $display("FAIL dz_clear sel=%b leds=%0d dz=%b want 00/9/0", sel4, leds4, dz4);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (leds4 !== 4'd15) begin
            errors++; $display("FAIL wrap_down leds=%0d want 15", leds4);
        end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (leds4 !== 4'd0) begin
            errors++; $display("FAIL wrap_up leds=%0d want 0", leds4);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (leds4 !== 4'd1) begin
            errors++; $display("FAIL wrap_hold leds=%0d want 1", leds4);
        end
        m_num[0] = 1;
    endtask

    task automatic test_priority();
        int cyc;
        press(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (sel4 !== 2'b01 || leds4 !== 4'd0) begin
            errors++; $display("FAIL prio_ok_up sel=%b leds=%0d want 01/0", sel4, leds4);
        end
        press(1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (leds4 !== 4'd0) begin
            errors++; $display("FAIL prio_up_down leds=%0d want 0", leds4);
        end
        set_val(1'b0, 1'b1, 3);
        run_divide(1'b0, 1'b1, cyc);
        checks++; if (cyc !== 4 || sel4 !== 2'b10 || leds4 !== 4'd0) begin
            errors++; $display("FAIL prio_noise_quot cycles=%0d sel=%b leds=%0d want 4/10/0", cyc, sel4, leds4);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (sel4 !== 2'b11 || leds4 !== 4'd1) begin
            errors++; $display("FAIL prio_noise_rem sel=%b leds=%0d want 11/1", sel4, leds4);
        end
        press(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (sel4 !== 2'b00 || leds4 !== 4'd1) begin
            errors++; $display("FAIL prio_num_kept sel=%b leds=%0d want 00/1", sel4, leds4);
        end
        // ok held across ENTER_NUM -> ENTER_DEN must not also launch the divide
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (sel4 !== 2'b01 || busy4 !== 1'b0 || leds4 !== 4'd3) begin
            errors++; $display("FAIL held_ok sel=%b busy=%b leds=%0d want 01/0/3", sel4, busy4, leds4);
        end
    endtask

    task automatic test_reset_mid_divide();
        int seen = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        if (busy4) seen++;
        tick();
        if (busy4) seen++;
        checks++; if (seen !== 2) begin
            errors++; $display("FAIL mid_busy seen=%0d want 2", seen);
        end
        rst = 1'b1;
        tick();
        checks++; if ({sel4, busy4, dz4, leds4} !== 8'h00) begin
            errors++; $display("FAIL mid_reset sel/busy/dz/leds=%b want 00000000", {sel4, busy4, dz4, leds4});
        end
        rst = 1'b0;
        tick();
        m_num = '{0, 0};
        m_den = '{0, 0};
    endtask

    task automatic test_random();
        int n, d, cyc, eq, er, ecyc;
        for (int i = 0; i < 25; i++) begin
            n = $urandom_range(0, 15);
            d = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 15);
            eq   = (d == 0) ? 15 : n / d;
            er   = (d == 0) ? n : n % d;
            ecyc = (d == 0) ? 1 : 4;
            set_val(1'b0, 1'b0, n);
            checks++; if (leds4 !== 4'(n)) begin
                errors++; $display("FAIL rnd_num[%0d] leds=%0d want %0d", i, leds4, n);
            end
            press(1'b0, 1'b0, 1'b0, 1'b1);
            set_val(1'b0, 1'b1, d);
            run_divide(1'b0, 1'b1, cyc);
            checks++; if (cyc !== ecyc || sel4 !== 2'b10 || leds4 !== 4'(eq) || dz4 !== (d == 0)) begin
                errors++; $display("FAIL rnd_quot[%0d] %0d/%0d cycles=%0d leds=%0d dz=%b want %0d/%0d/%0b",
                                   i, n, d, cyc, leds4, dz4, ecyc, eq, d == 0);
            end
            press(1'b0, 1'b0, 1'b0, 1'b1);
            checks++; if (sel4 !== 2'b11 || leds4 !== 4'(er)) begin
                errors++; $display("FAIL rnd_rem[%0d] %0d/%0d sel=%b leds=%0d want 11/%0d", i, n, d, sel4, leds4, er);
            end
            press(1'b0, 1'b0, 1'b0, 1'b1);
            checks++; if (sel4 !== 2'b00 || leds4 !== 4'(n) || dz4 !== 1'b0) begin
                errors++; $display("FAIL rnd_back[%0d] sel=%b leds=%0d dz=%b want 00/%0d/0", i, sel4, leds4, dz4, n);
            end
        end
    endtask

    task automatic test_width8();
        int cyc;
        int nums[2] = '{200, 255};
        int dens[2] = '{7, 1};
        int qs[2]   = '{28, 255};
        int rs[2]   = '{4, 0};
        for (int k = 0; k < 2; k++) begin
            set_val(1'b1, 1'b0, nums[k]);
            press(1'b1, 1'b0, 1'b0, 1'b1);
            set_val(1'b1, 1'b1, dens[k]);
            checks++; if (o_sel(1'b1) !== 1 || o_leds(1'b1) !== dens[k]) begin
                errors++; $display("FAIL w8_den[%0d] sel=%0d leds=%0d want 1/%0d", k, o_sel(1'b1), o_leds(1'b1), dens[k]);
            end
            run_divide(1'b1, 1'b0, cyc);
            checks++; if (cyc !== 8 || o_leds(1'b1) !== qs[k] || o_dz(1'b1) !== 1'b0) begin
                errors++; $display("FAIL w8_quot[%0d] cycles=%0d leds=%0d dz=%b want 8/%0d/0", k, cyc, o_leds(1'b1), o_dz(1'b1), qs[k]);
            end
            press(1'b1, 1'b0, 1'b0, 1'b1);
            checks++; if (o_sel(1'b1) !== 3 || o_leds(1'b1) !== rs[k]) begin
                errors++; $display("FAIL w8_rem[%0d] sel=%0d leds=%0d want 3/%0d", k, o_sel(1'b1), o_leds(1'b1), rs[k]);
            end
            press(1'b1, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        up4_n = 1'b1; down4_n = 1'b1; ok4_n = 1'b1;
        up8_n = 1'b1; down8_n = 1'b1; ok8_n = 1'b1;
        test_reset();
        test_basic();
        test_div_zero();
        test_wrap();
        test_priority();
        test_reset_mid_divide();
        test_random();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divisor_nb.md
# divisor_nb

Parametrised, multi-cycle successor of the 4-bit button-driven divider. The user enters a WIDTH-bit numerator and denominator with up/down/ok push-buttons, a sequential restoring divider computes quotient and remainder, and the LEDs step through operand entry, quotient and remainder. It adds edge-detected buttons, divide-by-zero handling and a busy indication. It sits directly behind the board buttons and drives the LED bank as the top-level user block.

## Interface
Parameters:
- WIDTH, 4, operand/result width in bits; legal 2..16.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- up_n  in  1  increment button, active-low, already synchronised/debounced to clk.
- down_n  in  1  decrement button, active-low, same conditioning.
- ok_n  in  1  advance button, active-low, same conditioning.
- leds  out  WIDTH  displayed value for the current phase.
- sel  out  2  display phase: 00 numerator, 01 denominator, 10 quotient, 11 remainder.
- busy  out  1  high while the divider iterates.
- div_zero  out  1  high while showing results of a division by zero.

## Operation
- Press detection: each button has a registered previous level; press = prev==1 and current==0. A held button produces exactly one press. After reset, prev registers = 1.
- FSM states: ENTER_NUM, ENTER_DEN, DIVIDE, SHOW_Q, SHOW_R.
  - ENTER_NUM: up press num+1, down press num-1, modulo 2^WIDTH (wrap at both ends). ok press -> ENTER_DEN.
  - ENTER_DEN: same editing on den. ok press -> DIVIDE; operands latched into the divider.
  - DIVIDE: restoring division, one quotient bit per cycle, MSB first; partial remainder WIDTH+1 bits. All presses ignored (and not queued). If den==0: skip iteration, quotient = all ones, remainder = num, div_zero=1.
  - SHOW_Q: ok press -> SHOW_R. up/down ignored.
  - SHOW_R: ok press -> ENTER_NUM; num and den retain their values for re-editing; div_zero cleared.
- Simultaneous presses: ok has priority (state advances, no edit). up and down together: no edit.
- Outputs: leds = num (ENTER_NUM), den (ENTER_DEN), 0 (DIVIDE), quotient (SHOW_Q), remainder (SHOW_R). sel = 00/01 in entry states, 10 in DIVIDE and SHOW_Q, 11 in SHOW_R. busy = 1 only in DIVIDE. div_zero = 1 only in SHOW_Q/SHOW_R after a den==0 division.
- Quotient and remainder registers hold until the next DIVIDE completes.

## Timing
- Reset (rst sampled high at an edge): state ENTER_NUM, num=den=quotient=remainder=0, leds=0, sel=00, busy=0, div_zero=0. rst overrides all other inputs, including mid-DIVIDE (division abandoned, results cleared).
- Edit latency: button low at edge t with prev high -> updated leds visible after edge t.
- Divide latency: ok press at edge t in ENTER_DEN -> DIVIDE from t, busy high for exactly WIDTH cycles (den!=0) or exactly 1 cycle (den==0), SHOW_Q with valid leds on the following cycle.
- A button held low across a state transition produces no further press until released (high for >=1 cycle) and pressed again.

## Test plan
- WIDTH=4: reset, 13 up presses, ok, 3 up presses, ok -> busy high 4 cycles, then sel=10 leds=4; ok -> sel=11 leds=1; ok -> sel=00 leds=13.
- WIDTH=4: num=9, den=0, ok -> busy 1 cycle, leds=15, div_zero=1; ok -> leds=9; ok -> div_zero=0.
- Wrap: from reset, 1 down press -> leds=15; 1 up press -> leds=0; up_n held low 20 cycles -> leds=1.
- Priority/ignore: up_n and ok_n fall same cycle in ENTER_NUM -> sel=01, num unchanged; presses during DIVIDE -> no effect on results or state.
- Reset mid-DIVIDE: rst high 2 cycles into busy -> next cycle sel=00, leds=0, busy=0, div_zero=0.
- WIDTH=8: 200 / 7 -> busy 8 cycles, quotient 28, remainder 4; 255 / 1 -> quotient 255, remainder 0.
